// File: rtl/ir_queue_if.sv
// ir_queue_if: bus-side handshake between the fetch unit and the instruction queue
interface ir_queue_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
);
  logic flush, data_on_ir, ir_rd, ir_valid, ir_full, ir_ovf;
  logic [WIDTH-1:0] data_2_ir, ir_2_bus;
  logic [CW-1:0] ir_count;
  modport master(output flush, data_on_ir, data_2_ir, ir_rd, input ir_2_bus, ir_valid, ir_full, ir_count, ir_ovf);
  modport slave(input flush, data_on_ir, data_2_ir, ir_rd, output ir_2_bus, ir_valid, ir_full, ir_count, ir_ovf);
endinterface

// File: rtl/ir_queue.sv
// ir_queue: instruction prefetch queue, circular buffer with sticky overflow flag
module ir_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input logic clk,
  input logic rst_n,
  ir_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, full, valid, wr, rd;
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    valid = cnt_q != '0;
    wr = q.data_on_ir && (!full || q.ir_rd) && !q.flush;
    rd = q.ir_rd && valid && !q.flush;
    wp_d = q.flush ? '0 : wp_q + AW'(wr);
    rp_d = q.flush ? '0 : rp_q + AW'(rd);
    cnt_d = q.flush ? '0 : cnt_q + CW'(wr) - CW'(rd);
    ovf_d = !q.flush && (ovf_q || (q.data_on_ir && full && !q.ir_rd));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  // storage is never cleared; the empty mask on ir_2_bus hides stale words
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q] <= q.data_2_ir;
  assign q.ir_2_bus = valid ? mem_q[rp_q] : '0;
  assign q.ir_valid = valid;
  assign q.ir_full = full;
  assign q.ir_count = cnt_q;
  assign q.ir_ovf = ovf_q;
endmodule
